// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD stopwatch controller.
// Includes the controller state encoding and the single-digit increment-with-wrap helper.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  // Anything at or above 9 wraps to 0, which also scrubs illegal codes.
  function automatic logic [BCD_W-1:0] bcd_next(input logic [BCD_W-1:0] q);
    return (q >= BCD_MAX) ? '0 : q + 4'd1;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit: async active-low reset, synchronous clear, increment with 9->0 wrap.
// at_max flags the carry-enabling value 9 for the next digit up the chain.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             res,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] q,
  output logic             at_max
);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= bcd_next(q);
    end
  end

  assign at_max = (q == BCD_MAX);

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Run/pause/clear stopwatch controller driving a chain of cascaded BCD digits.
// Optional lap-hold display freeze is compiled in with the LAP_HOLD_EN macro.
module bcd_stopwatch_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 10
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clr,
  input  logic                  lap,
  output logic [4*DIGITS-1:0]   disp,
  output logic                  running,
  output logic                  ovf
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  state_t state, state_next;
  logic [PRE_W-1:0] pre;
  logic tick;
  logic [DIGITS:0] carry;
  logic [DIGITS-1:0] at_max;
  logic [BCD_W*DIGITS-1:0] live;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (clr) begin
      state_next = IDLE;
    end else if (start && stop) begin
      state_next = state;
    end else begin
      case (state)
        IDLE:    if (start) state_next = RUN;
        RUN:     if (stop)  state_next = PAUSE;
        PAUSE:   if (start) state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  assign running = (state == RUN);
  assign tick    = (state == RUN) && (pre == PRE_LAST);

  // Resuming from PAUSE keeps pre so the partial tick period is not lost.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      pre <= '0;
    end else if (clr) begin
      pre <= '0;
    end else if ((state == IDLE) && start && !stop) begin
      pre <= '0;
    end else if (state == RUN) begin
      pre <= tick ? '0 : pre + PRE_W'(1);
    end
  end

  assign carry[0] = tick;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk    (clk),
      .res    (res),
      .clr    (clr),
      .inc    (carry[g]),
      .q      (live[g*BCD_W +: BCD_W]),
      .at_max (at_max[g])
    );
    assign carry[g+1] = carry[g] & at_max[g];
  end

  // A carry out of the top digit means the whole chain wrapped from all-9s.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      ovf <= 1'b0;
    end else if (clr) begin
      ovf <= 1'b0;
    end else if (carry[DIGITS]) begin
      ovf <= 1'b1;
    end
  end

`ifdef LAP_HOLD_EN
  logic                    hold_on;
  logic [BCD_W*DIGITS-1:0] hold_q;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      hold_on <= 1'b0;
      hold_q  <= '0;
    end else if (clr) begin
      hold_on <= 1'b0;
      hold_q  <= '0;
    end else if ((state == RUN) && lap) begin
      if (hold_on) begin
        hold_on <= 1'b0;
      end else begin
        hold_on <= 1'b1;
        hold_q  <= live;
      end
    end
  end

  assign disp = hold_on ? hold_q : live;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign disp       = live;
`endif

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Directed self-checking bench for bcd_stopwatch_ctrl with DIGITS=2, TICK_DIV=4.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_bcd_stopwatch_ctrl;

  logic       clk   = 1'b0;
  logic       res   = 1'b0;
  logic       start = 1'b0;
  logic       stop  = 1'b0;
  logic       clr   = 1'b0;
  logic       lap   = 1'b0;
  logic [7:0] disp;
  logic       running;
  logic       ovf;

  int total = 0;
  int bad   = 0;

`ifdef LAP_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  bcd_stopwatch_ctrl #(
    .DIGITS   (2),
    .TICK_DIV (4)
  ) dut (
    .clk     (clk),
    .res     (res),
    .start   (start),
    .stop    (stop),
    .clr     (clr),
    .lap     (lap),
    .disp    (disp),
    .running (running),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] expDisp,
                             input logic expRun, input logic expOvf);
    total++;
    assert (disp === expDisp) else begin
      bad++;
      $error("[TB] FAIL %s disp: got %h want %h", tag, disp, expDisp);
    end
    total++;
    assert (running === expRun) else begin
      bad++;
      $error("[TB] FAIL %s running: got %b want %b", tag, running, expRun);
    end
    total++;
    assert (ovf === expOvf) else begin
      bad++;
      $error("[TB] FAIL %s ovf: got %b want %b", tag, ovf, expOvf);
    end
  endtask

  initial begin
    applyStimulus(2);
    checkOutput("reset", 8'h00, 1'b0, 1'b0);
    res = 1'b1;
    applyStimulus(1);
    checkOutput("idle", 8'h00, 1'b0, 1'b0);

    // Start latency and first increments
    start = 1'b1;
    applyStimulus(1);
    start = 1'b0;
    checkOutput("start_E", 8'h00, 1'b1, 1'b0);
    applyStimulus(3);
    checkOutput("start_E3", 8'h00, 1'b1, 1'b0);
    applyStimulus(1);
    checkOutput("start_E4", 8'h01, 1'b1, 1'b0);
    applyStimulus(4);
    checkOutput("start_E8", 8'h02, 1'b1, 1'b0);

    // Digit carry and full-chain overflow
    applyStimulus(28);
    checkOutput("at_09", 8'h09, 1'b1, 1'b0);
    applyStimulus(4);
    checkOutput("carry_10", 8'h10, 1'b1, 1'b0);
    applyStimulus(356);
    checkOutput("at_99", 8'h99, 1'b1, 1'b0);
    applyStimulus(4);
    checkOutput("wrap_00", 8'h00, 1'b1, 1'b1);
    applyStimulus(4);
    checkOutput("after_wrap", 8'h01, 1'b1, 1'b1);

    // Pause with pre=2, then seamless resume
    applyStimulus(1);
    stop = 1'b1;
    applyStimulus(1);
    stop = 1'b0;
    checkOutput("pause", 8'h01, 1'b0, 1'b1);
    applyStimulus(20);
    checkOutput("pause_20", 8'h01, 1'b0, 1'b1);
    start = 1'b1;
    applyStimulus(1);
    start = 1'b0;
    checkOutput("resume_S", 8'h01, 1'b1, 1'b1);
    applyStimulus(1);
    checkOutput("resume_S1", 8'h01, 1'b1, 1'b1);
    applyStimulus(1);
    checkOutput("resume_S2", 8'h02, 1'b1, 1'b1);

    // clr beats start; start&stop together leave PAUSE alone
    applyStimulus(140);
    checkOutput("at_37", 8'h37, 1'b1, 1'b1);
    clr   = 1'b1;
    start = 1'b1;
    applyStimulus(1);
    clr   = 1'b0;
    start = 1'b0;
    checkOutput("clr_start", 8'h00, 1'b0, 1'b0);
    applyStimulus(5);
    checkOutput("idle_hold", 8'h00, 1'b0, 1'b0);
    start = 1'b1;
    applyStimulus(1);
    start = 1'b0;
    applyStimulus(1);
    stop = 1'b1;
    applyStimulus(1);
    stop = 1'b0;
    checkOutput("pause2", 8'h00, 1'b0, 1'b0);
    start = 1'b1;
    stop  = 1'b1;
    applyStimulus(1);
    start = 1'b0;
    stop  = 1'b0;
    checkOutput("start_stop", 8'h00, 1'b0, 1'b0);
    applyStimulus(8);
    checkOutput("pause2_8", 8'h00, 1'b0, 1'b0);
    start = 1'b1;
    applyStimulus(1);
    start = 1'b0;
    applyStimulus(1);
    checkOutput("resume2_S1", 8'h00, 1'b1, 1'b0);
    applyStimulus(1);
    checkOutput("resume2_S2", 8'h01, 1'b1, 1'b0);

    // Async reset mid-run with ovf set
    clr = 1'b1;
    applyStimulus(1);
    clr = 1'b0;
    start = 1'b1;
    applyStimulus(1);
    start = 1'b0;
    applyStimulus(624);
    checkOutput("at_56", 8'h56, 1'b1, 1'b1);
    #2;
    res = 1'b0;
    #1;
    checkOutput("async_res", 8'h00, 1'b0, 1'b0);
    applyStimulus(1);
    res = 1'b1;
    applyStimulus(1);
    start = 1'b1;
    applyStimulus(1);
    start = 1'b0;
    checkOutput("restart", 8'h00, 1'b1, 1'b0);
    applyStimulus(4);
    checkOutput("restart_01", 8'h01, 1'b1, 1'b0);

    // Lap hold, or live tracking when the feature is compiled out
    clr = 1'b1;
    applyStimulus(1);
    clr = 1'b0;
    start = 1'b1;
    applyStimulus(1);
    start = 1'b0;
    applyStimulus(48);
    checkOutput("at_12", 8'h12, 1'b1, 1'b0);
    lap = 1'b1;
    applyStimulus(1);
    lap = 1'b0;
    checkOutput("lap_on", 8'h12, 1'b1, 1'b0);
    applyStimulus(3);
    checkOutput("lap_13", HOLD ? 8'h12 : 8'h13, 1'b1, 1'b0);
    applyStimulus(4);
    checkOutput("lap_14", HOLD ? 8'h12 : 8'h14, 1'b1, 1'b0);
    applyStimulus(4);
    checkOutput("lap_15", HOLD ? 8'h12 : 8'h15, 1'b1, 1'b0);
    lap = 1'b1;
    applyStimulus(1);
    lap = 1'b0;
    checkOutput("lap_off", 8'h15, 1'b1, 1'b0);
    applyStimulus(3);
    checkOutput("live_16", 8'h16, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
